// File: rtl/ip_tile_shifter_sequencer_pkg.sv
// Shared types and CSR field positions for the shifter-tile sequencer.
package ip_tile_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    localparam int CSR_START_BIT = 15;
    localparam int CSR_OP_MSB    = 11;
    localparam int CSR_OP_LSB    = 8;
    localparam int CSR_SHAMT_MSB = 4;
    localparam int CSR_SHAMT_LSB = 0;
    localparam int CSR_DONE_BIT  = 0;
    localparam int CSR_ERR_BIT   = 1;

    // Command word seen by the tile; unused bits stay zero.
    function automatic logic [15:0] csr_cmd(input logic start, input logic [3:0] op,
                                            input logic [4:0] shamt);
        logic [15:0] v;
        v = 16'h0000;
        v[CSR_START_BIT] = start;
        v[CSR_OP_MSB:CSR_OP_LSB] = op;
        v[CSR_SHAMT_MSB:CSR_SHAMT_LSB] = shamt;
        return v;
    endfunction

endpackage

// File: rtl/ip_tile_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo NUM_REQ.
module ip_tile_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // Scan requesters starting at ptr; the sum is one bit wider so the wrap is explicit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        sum_s     = '0;
        idx_s     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum_s >= (IDX_W+1)'(NUM_REQ)) begin
                sum_s = sum_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IDX_W-1:0];
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                grant_idx    = idx_s;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/ip_tile_shifter_sequencer.sv
// Shares one shifter IP tile between NUM_REQ requesters: arbitrate, program the
// tile, wait for done (with watchdog) and return the result to the owner.
module ip_tile_shifter_sequencer
    import ip_tile_seq_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int REG_WIDTH   = 32,
    parameter int CSR_WIDTH   = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*4-1:0]           req_op,
    input  logic [NUM_REQ*5-1:0]           req_shamt,
    input  logic [NUM_REQ*REG_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*REG_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [REG_WIDTH-1:0]           rsp_data,
    output logic                           rsp_err,
    output logic                           busy,
    output logic [CSR_WIDTH-1:0]           tile_csr_in,
    input  logic                           tile_csr_in_re,
    output logic [REG_WIDTH-1:0]           tile_data_reg_a,
    output logic [REG_WIDTH-1:0]           tile_data_reg_b,
    input  logic [CSR_WIDTH-1:0]           tile_csr_out,
    input  logic                           tile_csr_out_we,
    input  logic [REG_WIDTH-1:0]           tile_data_reg_c
);

    localparam int         IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    state_t                 state_r;
    logic [IDX_W-1:0]       owner_r;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [7:0]             cnt_r;
    logic [CSR_WIDTH-1:0]   csr_r;
    logic [REG_WIDTH-1:0]   a_r;
    logic [REG_WIDTH-1:0]   b_r;
    logic [NUM_REQ-1:0]     rsp_valid_r;
    logic [REG_WIDTH-1:0]   rsp_data_r;
    logic                   rsp_err_r;
    logic                   busy_r;

    logic [NUM_REQ-1:0]     grant_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic [NUM_REQ-1:0]     req_ready_s;
    logic [NUM_REQ-1:0]     owner_onehot_s;
    logic [IDX_W-1:0]       ptr_next_s;
    logic                   done_s;
    logic                   timeout_s;
    logic                   finish_s;
    logic                   abort_s;
    logic                   ack_s;

    logic [3:0]             op_arr_s    [NUM_REQ];
    logic [4:0]             shamt_arr_s [NUM_REQ];
    logic [REG_WIDTH-1:0]   a_arr_s     [NUM_REQ];
    logic [REG_WIDTH-1:0]   b_arr_s     [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_arr_s[i]    = req_op[i*4 +: 4];
        assign shamt_arr_s[i] = req_shamt[i*5 +: 5];
        assign a_arr_s[i]     = req_a[i*REG_WIDTH +: REG_WIDTH];
        assign b_arr_s[i]     = req_b[i*REG_WIDTH +: REG_WIDTH];
    end

    ip_tile_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Grant is only offered while idle; it is the one combinational output.
    assign req_ready_s = (state_r == ST_IDLE) ? grant_s : '0;
    assign done_s      = tile_csr_out_we & tile_csr_out[CSR_DONE_BIT];
    assign timeout_s   = (cnt_r >= TIMEOUT_LIM);

    // Owner one-hot and the next round-robin pointer after this owner.
    always_comb begin
        owner_onehot_s          = '0;
        owner_onehot_s[owner_r] = 1'b1;
        if (owner_r == IDX_W'(NUM_REQ-1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = owner_r + IDX_W'(1);
        end
    end

    // Wait-state decode: a done report beats the watchdog; re+done together finishes at once.
    always_comb begin
        finish_s = 1'b0;
        abort_s  = 1'b0;
        ack_s    = 1'b0;
        case (state_r)
            ST_WAIT_ACK: begin
                finish_s = tile_csr_in_re & done_s;
                abort_s  = ~finish_s & timeout_s;
                ack_s    = tile_csr_in_re & ~finish_s & ~timeout_s;
            end
            ST_WAIT_DONE: begin
                finish_s = done_s;
                abort_s  = ~done_s & timeout_s;
                ack_s    = 1'b0;
            end
            default: begin
                finish_s = 1'b0;
                abort_s  = 1'b0;
                ack_s    = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with command/operand latches, watchdog and response registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r     <= ST_IDLE;
            owner_r     <= '0;
            rr_ptr_r    <= '0;
            cnt_r       <= 8'd0;
            csr_r       <= '0;
            a_r         <= '0;
            b_r         <= '0;
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req_ready_s) begin
                        owner_r <= grant_idx_s;
                        a_r     <= a_arr_s[grant_idx_s];
                        b_r     <= b_arr_s[grant_idx_s];
                        csr_r   <= CSR_WIDTH'(csr_cmd(1'b1, op_arr_s[grant_idx_s],
                                                      shamt_arr_s[grant_idx_s]));
                        busy_r  <= 1'b1;
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    cnt_r   <= 8'd0;
                    state_r <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK, ST_WAIT_DONE: begin
                    if (finish_s) begin
                        rsp_valid_r <= owner_onehot_s;
                        rsp_data_r  <= tile_data_reg_c;
                        rsp_err_r   <= tile_csr_out[CSR_ERR_BIT];
                        csr_r       <= '0;
                        state_r     <= ST_RESP;
                    end else if (abort_s) begin
                        rsp_valid_r <= owner_onehot_s;
                        rsp_data_r  <= '0;
                        rsp_err_r   <= 1'b1;
                        csr_r       <= '0;
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                        if (ack_s) begin
                            csr_r[CSR_START_BIT] <= 1'b0;
                            state_r              <= ST_WAIT_DONE;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                end
                ST_RESP: begin
                    rsp_valid_r <= '0;
                    rsp_data_r  <= '0;
                    rsp_err_r   <= 1'b0;
                    busy_r      <= 1'b0;
                    rr_ptr_r    <= ptr_next_s;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready       = req_ready_s;
    assign rsp_valid       = rsp_valid_r;
    assign rsp_data        = rsp_data_r;
    assign rsp_err         = rsp_err_r;
    assign busy            = busy_r;
    assign tile_csr_in     = csr_r;
    assign tile_data_reg_a = a_r;
    assign tile_data_reg_b = b_r;

endmodule

// File: tb/tb_ip_tile_shifter_sequencer.sv
// Randomized bench for ip_tile_shifter_sequencer with a behavioural tile and arbitration model.
module tb_ip_tile_shifter_sequencer;

    localparam int NR = 3;
    localparam int W  = 32;
    localparam int CW = 16;
    localparam int TO = 255;

    logic              clk = 1'b0;
    logic              arst;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid;
    logic [NR*4-1:0]   req_op;
    logic [NR*5-1:0]   req_shamt;
    logic [NR*W-1:0]   req_a, req_b;
    logic [W-1:0]      rsp_data;
    logic              rsp_err, busy;
    logic [CW-1:0]     tile_csr_in, tile_csr_out;
    logic              tile_csr_in_re, tile_csr_out_we;
    logic [W-1:0]      tile_data_reg_a, tile_data_reg_b, tile_data_reg_c;

    int n_chk = 0;
    int n_err = 0;
    int ptr_m = 0;
    logic [3:0]   op_m [NR];
    logic [4:0]   sh_m [NR];
    logic [W-1:0] a_m  [NR];
    logic [W-1:0] b_m  [NR];

    ip_tile_shifter_sequencer #(
        .NUM_REQ(NR), .REG_WIDTH(W), .CSR_WIDTH(CW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_shamt(req_shamt), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .tile_csr_in(tile_csr_in), .tile_csr_in_re(tile_csr_in_re),
        .tile_data_reg_a(tile_data_reg_a), .tile_data_reg_b(tile_data_reg_b),
        .tile_csr_out(tile_csr_out), .tile_csr_out_we(tile_csr_out_we),
        .tile_data_reg_c(tile_data_reg_c)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // What the shifter tile computes for a given command.
    function automatic logic [W-1:0] tile_fn(input logic [3:0] op, input logic [4:0] sh,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'd0:    return a << sh;
            4'd1:    return a >> sh;
            4'd2:    return W'($signed(a) >>> sh);
            default: return (a << sh) ^ b;
        endcase
    endfunction

    function automatic int pick(input int ptr, input logic [NR-1:0] m);
        for (int k = 0; k < NR; k++) begin
            if (m[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic new_ops();
        for (int i = 0; i < NR; i++) begin
            op_m[i] = 4'($urandom_range(0, 3));
            sh_m[i] = 5'($urandom);
            a_m[i]  = $urandom;
            b_m[i]  = $urandom;
        end
    endtask

    task automatic drive_req(input logic [NR-1:0] mask);
        for (int i = 0; i < NR; i++) begin
            req_op[i*4 +: 4]    = op_m[i];
            req_shamt[i*5 +: 5] = sh_m[i];
            req_a[i*W +: W]     = a_m[i];
            req_b[i*W +: W]     = b_m[i];
        end
        req_valid = mask;
    endtask

    task automatic tile_idle();
        tile_csr_in_re  = 1'b0;
        tile_csr_out_we = 1'b0;
        tile_csr_out    = 16'h0000;
        tile_data_reg_c = $urandom;
    endtask

    // One job: ack_dly 0 = tile never acks; done_dly 0 = done with the ack; >=500 = never done.
    task automatic run_job(input logic [NR-1:0] mask, input int ack_dly, input int done_dly,
                           input logic terr, input int rst_at);
        int g, r_cyc, d_cyc, exp_rsp, got;
        logic timeout;
        logic [CW-1:0] csr_start, csr_hold;
        logic [W-1:0] c_exp, tc;
        @(negedge clk);
        drive_req(mask);
        tile_idle();
        #1;
        g = pick(ptr_m, mask);
        check_eq("grant", 64'(req_ready), 64'(onehot(g)));
        check_eq("idle_busy", 64'(busy), 64'd0);
        csr_start = {1'b1, 3'b000, op_m[g], 3'b000, sh_m[g]};
        csr_hold  = csr_start & 16'h7fff;
        c_exp     = tile_fn(op_m[g], sh_m[g], a_m[g], b_m[g]);
        timeout   = (ack_dly == 0) || (done_dly >= 500);
        r_cyc     = 1 + ack_dly;
        d_cyc     = r_cyc + done_dly;
        exp_rsp   = d_cyc + 1;
        got       = -1;
        tc        = '0;
        for (int cyc = 1; cyc <= TO + 10 && got < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check_eq("load_busy", 64'(busy), 64'd1);
                check_eq("load_csr", 64'(tile_csr_in), 64'(csr_start));
                check_eq("load_a", 64'(tile_data_reg_a), 64'(a_m[g]));
                check_eq("load_b", 64'(tile_data_reg_b), 64'(b_m[g]));
                check_eq("busy_ready", 64'(req_ready), 64'd0);
            end
            if (ack_dly > 0 && done_dly > 0 && cyc == r_cyc + 1)
                check_eq("csr_hold", 64'(tile_csr_in), 64'(csr_hold));
            if (rst_at == cyc) begin
                arst = 1'b1;
                req_valid = '0;
                tile_idle();
                #1;
                check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
                check_eq("rst_busy", 64'(busy), 64'd0);
                check_eq("rst_csr", 64'(tile_csr_in), 64'd0);
                check_eq("rst_a", 64'(tile_data_reg_a), 64'd0);
                check_eq("rst_ready", 64'(req_ready), 64'd0);
                repeat (3) begin
                    @(negedge clk);
                    check_eq("rst_no_rsp", 64'(rsp_valid), 64'd0);
                end
                arst = 1'b0;
                ptr_m = 0;
                return;
            end
            if (rsp_valid != '0) begin
                got = cyc;
                check_eq("rsp_owner", 64'(rsp_valid), 64'(onehot(g)));
                check_eq("rsp_data", 64'(rsp_data), timeout ? 64'd0 : 64'(c_exp));
                check_eq("rsp_err", 64'(rsp_err), timeout ? 64'd1 : 64'(terr));
                check_eq("rsp_csr", 64'(tile_csr_in), 64'd0);
                tile_idle();
            end else begin
                tile_idle();
                if (ack_dly > 0 && cyc == r_cyc) begin
                    tile_csr_in_re = 1'b1;
                    tc = tile_fn(tile_csr_in[11:8], tile_csr_in[4:0], tile_data_reg_a, tile_data_reg_b);
                end
                if (ack_dly > 0 && done_dly < 500 && cyc == d_cyc) begin
                    tile_csr_out_we = 1'b1;
                    tile_csr_out    = {14'h0000, terr, 1'b1};
                    tile_data_reg_c = tc;
                end else if (ack_dly > 0 && done_dly >= 2 && cyc == r_cyc + 1) begin
                    tile_csr_out_we = 1'b1;
                    tile_csr_out    = 16'h0002;
                end
            end
        end
        if (timeout) check_eq("timeout_lat", 64'(got >= TO + 1 && got <= TO + 4), 64'd1);
        else         check_eq("latency", 64'(got), 64'(exp_rsp));
        ptr_m = (g + 1) % NR;
    endtask

    initial begin
        logic [NR-1:0] m;
        arst = 1'b1;
        req_valid = '0; req_op = '0; req_shamt = '0; req_a = '0; req_b = '0;
        tile_idle();
        repeat (3) @(negedge clk);
        check_eq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("reset_rsp_data", 64'(rsp_data), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_csr", 64'(tile_csr_in), 64'd0);
        arst = 1'b0;

        // Contention: grants 0,1,0,1
        for (int j = 0; j < 4; j++) begin
            new_ops();
            run_job(3'b011, 1, 2, 1'b0, 0);
        end
        // Spec single job on requester 0
        new_ops();
        op_m[0] = 4'd1; sh_m[0] = 5'd5; a_m[0] = 32'hA5A5A5A5; b_m[0] = 32'h12A2A3A5;
        run_job(3'b001, 1, 3, 1'b0, 0);
        // Watchdog: never acked, then hung after ack; each followed by a normal job
        new_ops(); run_job(3'b100, 0, 0, 1'b0, 0);
        new_ops(); run_job(3'b110, 2, 1, 1'b0, 0);
        new_ops(); run_job(3'b010, 1, 1000, 1'b0, 0);
        // Tile error report and same-cycle re+done
        new_ops(); run_job(3'b001, 2, 2, 1'b1, 0);
        new_ops(); run_job(3'b111, 1, 0, 1'b0, 0);
        new_ops(); run_job(3'b101, 3, 0, 1'b1, 0);
        // Reset in WAIT_DONE after ptr has moved off 0
        new_ops(); run_job(3'b001, 1, 1, 1'b0, 0);
        new_ops(); run_job(3'b010, 1, 4, 1'b0, 4);
        new_ops(); run_job(3'b011, 1, 1, 1'b0, 0);
        // Random traffic
        for (int j = 0; j < 40; j++) begin
            new_ops();
            m = NR'($urandom_range(1, (1 << NR) - 1));
            run_job(m, $urandom_range(1, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
